// File: rtl/match_controller.sv
// rtl/match_controller.sv - Pong game-flow sequencer driving the BCD score counter
module match_controller #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 60,
  parameter int HOLD_TICKS  = 30,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic [3:0] p1_tens,
  input  logic [3:0] p1_units,
  input  logic [3:0] p2_tens,
  input  logic [3:0] p2_units,
  output logic       score1,
  output logic       score2,
  output logic       score_clear,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SERVE = 3'd2,
    PLAY  = 3'd3,
    SCORE = 3'd4,
    CHECK = 3'd5,
    HOLD  = 3'd6,
    OVER  = 3'd7
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] timer, timer_nx;
  logic          dir_q, dir_nx;
  logic          win_q, win_nx;
  logic          scorer_q, scorer_nx;   // 0 = player 1, 1 = player 2
  logic          start_d;
  logic          start_rise;
  logic [6:0]    p1_val, p2_val, scorer_val;

  assign start_rise = start & ~start_d;
  assign p1_val     = 7'(p1_tens) * 7'd10 + 7'(p1_units);
  assign p2_val     = 7'(p2_tens) * 7'd10 + 7'(p2_units);
  assign scorer_val = scorer_q ? p2_val : p1_val;

  // State register; start_d resets high so a button held through reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      dir_q    <= 1'b1;
      win_q    <= 1'b0;
      scorer_q <= 1'b0;
      start_d  <= 1'b1;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      dir_q    <= dir_nx;
      win_q    <= win_nx;
      scorer_q <= scorer_nx;
      start_d  <= start;
    end
  end

  // Next-state logic; timers expire on a tick at 1 (or 0, so a zero count behaves as 1)
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    dir_nx    = dir_q;
    win_nx    = win_q;
    scorer_nx = scorer_q;
    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_nx = CLEAR;
          dir_nx   = 1'b1;
          win_nx   = 1'b0;
        end
      end
      CLEAR: begin
        state_nx = SERVE;
        timer_nx = CW'(SERVE_TICKS);
      end
      SERVE: begin
        if (tick) begin
          if (timer <= CW'(1)) begin
            state_nx = PLAY;
            timer_nx = '0;
          end else begin
            timer_nx = timer - CW'(1);
          end
        end
      end
      PLAY: begin
        if (miss_left) begin
          state_nx  = SCORE;
          dir_nx    = 1'b0;
          scorer_nx = 1'b1;
        end else if (miss_right) begin
          state_nx  = SCORE;
          dir_nx    = 1'b1;
          scorer_nx = 1'b0;
        end
      end
      SCORE: state_nx = CHECK;
      CHECK: begin
        if (scorer_val >= 7'(WIN_SCORE)) begin
          state_nx = OVER;
          win_nx   = scorer_q;
        end else begin
          state_nx = HOLD;
          timer_nx = CW'(HOLD_TICKS);
        end
      end
      HOLD: begin
        if (tick) begin
          if (timer <= CW'(1)) begin
            state_nx = SERVE;
            timer_nx = CW'(SERVE_TICKS);
          end else begin
            timer_nx = timer - CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign score1      = (state == SCORE) && !scorer_q;
  assign score2      = (state == SCORE) &&  scorer_q;
  assign score_clear = (state == CLEAR);
  assign ball_run    = (state == PLAY);
  assign ball_center = (state == IDLE) || (state == SERVE);
  assign game_over   = (state == OVER);
  assign serve_dir   = dir_q;
  assign winner      = win_q;
  assign state_dbg   = state;

endmodule
